// File: rtl/bt_pkg.sv
// Shared constants and FSM encoding for the Bluetooth telemetry transmitter.
// Packet length depends on BT_TX_CHECKSUM_EN (see bt_telemetry_tx).
package bt_pkg;

   localparam logic [7:0]  BT_HDR      = 8'hA5;
   localparam int unsigned BT_LEN_BASE = 4;
   localparam int unsigned BT_LEN_CSUM = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } bt_state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: 1 start, 8 data LSB first, 1 stop, BIT_CYC cycles per bit.
// A load on the final stop cycle chains the next byte with no idle gap.
module uart_tx_byte
   import bt_pkg::*;
#(
   parameter int unsigned BIT_CYC = 16
) (
   input  logic       WF_CLK,
   input  logic       WF_BUTTON,
   input  logic       load,
   input  logic [7:0] data,
   output logic       Tx,
   output logic       done
);

   localparam int unsigned BW       = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYC - 1);

   bt_state_t     state;
   logic [BW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_end;

   assign bit_end = (bit_cnt == BIT_LAST);
   // Decoded from state so the sequencer can chain the next byte on the same edge
   assign done    = (state == ST_STOP) && bit_end;

   always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
      if (!WF_BUTTON) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         Tx      <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               Tx      <= 1'b1;
               if (load) begin
                  state <= ST_START;
                  shreg <= data;
                  Tx    <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  state   <= ST_DATA;
                  Tx      <= shreg[0];
                  shreg   <= {1'b0, shreg[7:1]};
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                     Tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     Tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (load) begin
                     state <= ST_START;
                     shreg <= data;
                     Tx    <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bt_telemetry_tx.sv
// Periodic telemetry packet generator: header, bumpers, encoder counts over UART.
// Define BT_TX_CHECKSUM_EN to append an XOR checksum byte (5-byte packet).
module bt_telemetry_tx
   import bt_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 16_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned PERIOD_CYC = 1_600_000
) (
   input  logic       WF_CLK,
   input  logic       WF_BUTTON,
   input  logic       enable,
   input  logic [5:0] bumper,
   input  logic       motorL_encdr,
   input  logic       motorR_encdr,
   output logic       Tx,
   output logic       busy,
   output logic       pkt_done
);

   localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
`ifdef BT_TX_CHECKSUM_EN
   localparam int unsigned PKT_LEN = BT_LEN_CSUM;
`else
   localparam int unsigned PKT_LEN = BT_LEN_BASE;
`endif
   localparam logic [2:0]    LAST_IDX = 3'(PKT_LEN - 1);
   localparam int unsigned   PW       = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam logic [PW-1:0] P_LAST   = PW'(PERIOD_CYC - 1);

   logic [5:0]    bump_s1, bump_s2;
   logic [2:0]    enc_l_s, enc_r_s;
   logic          rise_l, rise_r;
   logic [7:0]    cnt_l, cnt_r;
   logic [5:0]    snap_bump;
   logic [7:0]    snap_l, snap_r;
   logic [PW-1:0] period_cnt;
   logic [2:0]    byte_idx, nxt_idx;
   logic          trigger, uart_done, last_byte, load;
   logic [7:0]    load_data;

   always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
      if (!WF_BUTTON) begin
         bump_s1 <= '0;
         bump_s2 <= '0;
         enc_l_s <= '0;
         enc_r_s <= '0;
      end else begin
         bump_s1 <= bumper;
         bump_s2 <= bump_s1;
         enc_l_s <= {enc_l_s[1:0], motorL_encdr};
         enc_r_s <= {enc_r_s[1:0], motorR_encdr};
      end
   end

   assign rise_l    = enc_l_s[1] & ~enc_l_s[2];
   assign rise_r    = enc_r_s[1] & ~enc_r_s[2];
   assign trigger   = !busy && enable && (period_cnt == P_LAST);
   assign last_byte = (byte_idx == LAST_IDX);
   assign nxt_idx   = byte_idx + 3'd1;
   assign load      = trigger || (uart_done && !last_byte);

   always_comb begin
      load_data = BT_HDR;
      if (!trigger) begin
         case (nxt_idx)
            3'd1:    load_data = {2'b00, snap_bump};
            3'd2:    load_data = snap_l;
            3'd3:    load_data = snap_r;
`ifdef BT_TX_CHECKSUM_EN
            3'd4:    load_data = {2'b00, snap_bump} ^ snap_l ^ snap_r;
`endif
            default: load_data = BT_HDR;
         endcase
      end
   end

   always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
      if (!WF_BUTTON) begin
         period_cnt <= '0;
      end else if (busy || !enable || period_cnt == P_LAST) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + 1'b1;
      end
   end

   // An edge landing on the snapshot cycle seeds the next window instead
   always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
      if (!WF_BUTTON) begin
         cnt_l     <= '0;
         cnt_r     <= '0;
         snap_bump <= '0;
         snap_l    <= '0;
         snap_r    <= '0;
      end else if (trigger) begin
         snap_bump <= bump_s2;
         snap_l    <= cnt_l;
         snap_r    <= cnt_r;
         cnt_l     <= {7'd0, rise_l};
         cnt_r     <= {7'd0, rise_r};
      end else begin
         if (rise_l) cnt_l <= sat_inc(cnt_l);
         if (rise_r) cnt_r <= sat_inc(cnt_r);
      end
   end

   always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
      if (!WF_BUTTON) begin
         busy     <= 1'b0;
         pkt_done <= 1'b0;
         byte_idx <= '0;
      end else if (trigger) begin
         busy     <= 1'b1;
         pkt_done <= 1'b0;
         byte_idx <= '0;
      end else if (uart_done) begin
         if (last_byte) begin
            busy     <= 1'b0;
            pkt_done <= 1'b1;
            byte_idx <= '0;
         end else begin
            pkt_done <= 1'b0;
            byte_idx <= nxt_idx;
         end
      end else begin
         pkt_done <= 1'b0;
      end
   end

   uart_tx_byte #(
      .BIT_CYC(BIT_CYC)
   ) u_ser (
      .WF_CLK   (WF_CLK),
      .WF_BUTTON(WF_BUTTON),
      .load     (load),
      .data     (load_data),
      .Tx       (Tx),
      .done     (uart_done)
   );

endmodule

// File: tb/tb_bt_telemetry_tx.sv
// Self-checking bench for bt_telemetry_tx with a timeline-level reference model.
module tb_bt_telemetry_tx;

   localparam int unsigned CLK_HZ = 16_000_000;
   localparam int unsigned BAUD   = 1_000_000;
   localparam int unsigned P      = 100;
   localparam int unsigned B      = CLK_HZ / BAUD;
   localparam int unsigned FRAME  = 10 * B;
`ifdef BT_TX_CHECKSUM_EN
   localparam int unsigned LEN      = 5;
   localparam int unsigned EXP_BUSY = 800;
`else
   localparam int unsigned LEN      = 4;
   localparam int unsigned EXP_BUSY = 640;
`endif
   localparam int unsigned PKT_CYC = LEN * FRAME;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       enable = 1'b0;
   logic [5:0] bumper = '0;
   logic       encl = 1'b0;
   logic       encr = 1'b0;
   logic       Tx, busy, pkt_done;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   bt_telemetry_tx #(
      .CLK_HZ(CLK_HZ),
      .BAUD(BAUD),
      .PERIOD_CYC(P)
   ) dut (
      .WF_CLK(clk),
      .WF_BUTTON(rst_n),
      .enable(enable),
      .bumper(bumper),
      .motorL_encdr(encl),
      .motorR_encdr(encr),
      .Tx(Tx),
      .busy(busy),
      .pkt_done(pkt_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [5:0] hb[4];
   logic       hl[4], hr[4];
   int         m_idle, m_t, m_cl, m_cr, m_pkts;
   bit         m_in_pkt;
   logic [7:0] m_bytes[5];
   logic [7:0] left_hist[$];
   logic       e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            hb[i] = '0; hl[i] = 1'b0; hr[i] = 1'b0;
         end
         m_idle = 0; m_t = 0; m_cl = 0; m_cr = 0; m_in_pkt = 1'b0;
         e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end else begin
         bit trig, rl, rr;
         int k, b;
         for (int i = 3; i > 0; i--) begin
            hb[i] = hb[i-1]; hl[i] = hl[i-1]; hr[i] = hr[i-1];
         end
         hb[0] = bumper; hl[0] = encl; hr[0] = encr;
         rl = hl[2] && !hl[3];
         rr = hr[2] && !hr[3];
         e_done = 1'b0;
         trig = 1'b0;
         if (!m_in_pkt) begin
            if (!enable) m_idle = 0;
            else if (m_idle == P - 1) trig = 1'b1;
            else m_idle++;
         end
         if (trig) begin
            m_bytes[0] = 8'hA5;
            m_bytes[1] = {2'b00, hb[2]};
            m_bytes[2] = 8'(m_cl);
            m_bytes[3] = 8'(m_cr);
            m_bytes[4] = m_bytes[1] ^ m_bytes[2] ^ m_bytes[3];
            left_hist.push_back(m_bytes[2]);
            m_pkts++;
            m_cl = rl ? 1 : 0;
            m_cr = rr ? 1 : 0;
            m_in_pkt = 1'b1; m_t = 0; m_idle = 0;
         end else begin
            if (rl && m_cl < 255) m_cl++;
            if (rr && m_cr < 255) m_cr++;
            if (m_in_pkt) begin
               m_t++;
               if (m_t == PKT_CYC) begin
                  m_in_pkt = 1'b0;
                  e_done = 1'b1;
               end
            end
         end
         e_busy = m_in_pkt;
         if (m_in_pkt) begin
            k = m_t / FRAME;
            b = (m_t % FRAME) / B;
            e_tx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_bytes[k][b-1];
         end else begin
            e_tx = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("tx", Tx, e_tx);
         check("busy", busy, e_busy);
         check("pkt_done", pkt_done, e_done);
      end
   end

   // ---------------- observation counters ----------------
   int busy_run = 0, last_busy = 0, done_cnt = 0;
   always @(negedge clk) begin
      if (pkt_done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_run++;
      else begin
         if (busy_run != 0) last_busy = busy_run;
         busy_run = 0;
      end
   end

   // which: 0 = busy high, 1 = pkt_done high
   task automatic wait_for(input string name, input int which, input int limit);
      bit seen = 1'b0;
      for (int n = 0; n < limit && !seen; n++) begin
         @(negedge clk);
         seen = (which == 0) ? (busy === 1'b1) : (pkt_done === 1'b1);
      end
      check(name, seen, 1'b1);
   endtask

   initial begin
      #(4_000_000);
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      int idx, n, txlow, d0;
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      check("rst_tx", Tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", pkt_done, 1'b0);
      repeat (3) @(negedge clk);
      bumper = 6'b000101;
      enable = 1'b1;
      #2 rst_n = 1'b1;

      // first window: 3 left and 7 right edges
      for (int i = 0; i < 7; i++) begin
         encr = 1'b1;
         if (i < 3) encl = 1'b1;
         repeat (2) @(negedge clk);
         encl = 1'b0; encr = 1'b0;
         repeat (2) @(negedge clk);
      end
      wait_for("pkt1_start", 0, 200);
      wait_for("pkt1_done", 1, 1000);
      @(negedge clk);
      check("pkt1_b0", m_bytes[0], 8'hA5);
      check("pkt1_b1", m_bytes[1], 8'h05);
      check("pkt1_b2", m_bytes[2], 8'h03);
      check("pkt1_b3", m_bytes[3], 8'h07);
`ifdef BT_TX_CHECKSUM_EN
      check("pkt1_b4", m_bytes[4], 8'h01);
`endif
      check("pkt1_busy_len", last_busy, EXP_BUSY);
      check("pkt1_done_cnt", done_cnt, 1);

      // saturation: 300 left edges in one window, then an empty window
      wait_for("sat_start", 0, 200);
      idx = m_pkts;
      for (int i = 0; i < 600; i++) begin
         encl = ~encl;
         @(negedge clk);
      end
      wait_for("sat_prev_done", 1, 1000);
      wait_for("sat_pkt_start", 0, 200);
      wait_for("sat_pkt_done", 1, 1000);
      wait_for("zero_pkt_start", 0, 200);
      check("hist_len", left_hist.size(), idx + 2);
      check("sat_left", left_hist[idx], 8'hFF);
      check("zero_left", left_hist[idx+1], 8'h00);

      // edge coincident with the snapshot cycle
      wait_for("coin_prev_done", 1, 1000);
      idx = m_pkts;
      repeat (P - 3) @(negedge clk);
      encl = 1'b1;
      repeat (3) @(negedge clk);
      encl = 1'b0;
      wait_for("coin_pkt_done", 1, 1000);
      wait_for("coin_next_start", 0, 200);
      check("coin_cur_left", left_hist[idx], 8'h00);
      check("coin_next_left", left_hist[idx+1], 8'h01);

      // enable dropped during byte 2
      repeat (2 * FRAME + 40) @(negedge clk);
      enable = 1'b0;
      d0 = done_cnt;
      wait_for("en_drop_done", 1, 1000);
      txlow = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (Tx !== 1'b1 || busy !== 1'b0) txlow++;
      end
      check("en_drop_done_cnt", done_cnt - d0, 1);
      check("en_drop_quiet", txlow, 0);

      // reset mid DATA
      enable = 1'b1;
      wait_for("rst_pkt_start", 0, 200);
      repeat (40) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_tx", Tx, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", pkt_done, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         n++;
         if (busy === 1'b1) break;
      end
      check("first_after_rst", n, 100);

      // randomized activity checked cycle-by-cycle against the model
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ($urandom_range(7, 0) == 0) encl = ~encl;
         if ($urandom_range(4, 0) == 0) encr = ~encr;
         if ($urandom_range(199, 0) == 0) bumper = 6'($urandom);
         if ($urandom_range(999, 0) == 0) enable = ~enable;
      end
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
